// File: rtl/p_status_reg.sv
// 6502 processor status register (P).
// Captures ALU flags under control-unit enables, services CLC/SEC/CLI/SEI/
// CLD/SED/CLV, BIT and PLP/RTI pulls, sets I on interrupt entry, formats the
// push byte and keeps an IRQ mask that lags I by one instruction boundary.
// Optional build macro CMOS_DCLR_EN: interrupt entry also clears D (65C02).
module p_status_reg #(
    parameter logic [7:0] RESET_P = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_co,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_op,
    input  logic [2:0] flag_op,
    input  logic       pull,
    input  logic [7:0] db_in,
    input  logic       int_entry,
    input  logic       sync,
    input  logic       brk_push,
    output logic [7:0] p_out,
    output logic       n_flag,
    output logic       v_flag,
    output logic       d_flag,
    output logic       i_flag,
    output logic       z_flag,
    output logic       c_flag,
    output logic       irq_mask
);

    localparam logic [2:0] OP_CLC = 3'b001;
    localparam logic [2:0] OP_SEC = 3'b010;
    localparam logic [2:0] OP_CLI = 3'b011;
    localparam logic [2:0] OP_SEI = 3'b100;
    localparam logic [2:0] OP_CLD = 3'b101;
    localparam logic [2:0] OP_SED = 3'b110;
    localparam logic [2:0] OP_CLV = 3'b111;

    logic n_q, v_q, d_q, i_q, z_q, c_q, irq_mask_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d, irq_mask_d;

    // Next-flag selection; each flag walks its own priority chain so that
    // independent enables on different flags all take effect in one cycle.
    always_comb begin
        n_d        = n_q;
        v_d        = v_q;
        d_d        = d_q;
        i_d        = i_q;
        z_d        = z_q;
        c_d        = c_q;
        irq_mask_d = irq_mask_q;

        if (pull) begin
            n_d = db_in[7];
        end else if (bit_op) begin
            n_d = db_in[7];
        end else if (upd_nz) begin
            n_d = alu_n;
        end

        if (pull) begin
            v_d = db_in[6];
        end else if (flag_op == OP_CLV) begin
            v_d = 1'b0;
        end else if (bit_op) begin
            v_d = db_in[6];
        end else if (upd_v) begin
            v_d = alu_v;
        end

        if (pull) begin
            d_d = db_in[3];
`ifdef CMOS_DCLR_EN
        end else if (int_entry) begin
            d_d = 1'b0;
`endif
        end else if (flag_op == OP_CLD) begin
            d_d = 1'b0;
        end else if (flag_op == OP_SED) begin
            d_d = 1'b1;
        end

        if (pull) begin
            i_d = db_in[2];
        end else if (int_entry) begin
            i_d = 1'b1;
        end else if (flag_op == OP_CLI) begin
            i_d = 1'b0;
        end else if (flag_op == OP_SEI) begin
            i_d = 1'b1;
        end

        if (pull) begin
            z_d = db_in[1];
        end else if (bit_op || upd_nz) begin
            z_d = alu_z;
        end

        if (pull) begin
            c_d = db_in[0];
        end else if (flag_op == OP_CLC) begin
            c_d = 1'b0;
        end else if (flag_op == OP_SEC) begin
            c_d = 1'b1;
        end else if (upd_c) begin
            c_d = alu_co;
        end

        // The mask samples the pre-update I, so an I change lands one
        // instruction later in IRQ arbitration.
        if (sync) begin
            irq_mask_d = i_q;
        end
    end

    // Flag and mask registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q        <= RESET_P[7];
            v_q        <= RESET_P[6];
            d_q        <= RESET_P[3];
            i_q        <= RESET_P[2];
            z_q        <= RESET_P[1];
            c_q        <= RESET_P[0];
            irq_mask_q <= 1'b1;
        end else begin
            n_q        <= n_d;
            v_q        <= v_d;
            d_q        <= d_d;
            i_q        <= i_d;
            z_q        <= z_d;
            c_q        <= c_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign p_out    = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
    assign n_flag   = n_q;
    assign v_flag   = v_q;
    assign d_flag   = d_q;
    assign i_flag   = i_q;
    assign z_flag   = z_q;
    assign c_flag   = c_q;
    assign irq_mask = irq_mask_q;

endmodule
